// File: rtl/lcd_ctrl_pkg.sv
// Shared command codes, controller states and elaboration helpers for the
// parametrised LCD image controller.
package lcd_ctrl_pkg;

  localparam logic [3:0] CMD_WRTBK = 4'd0;
  localparam logic [3:0] CMD_UP    = 4'd1;
  localparam logic [3:0] CMD_DOWN  = 4'd2;
  localparam logic [3:0] CMD_LEFT  = 4'd3;
  localparam logic [3:0] CMD_RIGHT = 4'd4;
  localparam logic [3:0] CMD_AVG   = 4'd5;
  localparam logic [3:0] CMD_MIRX  = 4'd6;
  localparam logic [3:0] CMD_MIRY  = 4'd7;
  localparam logic [3:0] CMD_MAX   = 4'd8;
  localparam logic [3:0] CMD_MIN   = 4'd9;
  localparam logic [3:0] CMD_RCW   = 4'd10;
  localparam logic [3:0] CMD_RCCW  = 4'd11;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    IDLE  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  // Ceiling log2, used to size addresses from the image dimensions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/lcd_win_alu.sv
// Combinational 2x2 window operator: produces the replacement pixels and a
// write enable for the pixel-modifying commands; moves and no-ops leave we=0.
module lcd_win_alu
  import lcd_ctrl_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic [DW-1:0] p1,
  input  logic [DW-1:0] p2,
  input  logic [DW-1:0] p3,
  input  logic [DW-1:0] p4,
  input  logic [3:0]    cmd,
  output logic [DW-1:0] q1,
  output logic [DW-1:0] q2,
  output logic [DW-1:0] q3,
  output logic [DW-1:0] q4,
  output logic          we
);

  localparam int unsigned SW = DW + 2;

  logic [SW-1:0] sum;
  logic [DW-1:0] avg;
  logic [DW-1:0] mx12;
  logic [DW-1:0] mx34;
  logic [DW-1:0] mx;
  logic [DW-1:0] mn12;
  logic [DW-1:0] mn34;
  logic [DW-1:0] mn;

  // Two guard bits keep the four-pixel sum exact before the divide by four.
  always_comb begin
    sum  = SW'(p1) + SW'(p2) + SW'(p3) + SW'(p4);
    avg  = DW'(sum >> 2);
    mx12 = (p1 > p2) ? p1 : p2;
    mx34 = (p3 > p4) ? p3 : p4;
    mx   = (mx12 > mx34) ? mx12 : mx34;
    mn12 = (p1 < p2) ? p1 : p2;
    mn34 = (p3 < p4) ? p3 : p4;
    mn   = (mn12 < mn34) ? mn12 : mn34;
  end

  always_comb begin
    q1 = p1;
    q2 = p2;
    q3 = p3;
    q4 = p4;
    we = 1'b0;
    case (cmd)
      CMD_AVG: begin
        q1 = avg; q2 = avg; q3 = avg; q4 = avg; we = 1'b1;
      end
      CMD_MIRX: begin
        q1 = p3; q2 = p4; q3 = p1; q4 = p2; we = 1'b1;
      end
      CMD_MIRY: begin
        q1 = p2; q2 = p1; q3 = p4; q4 = p3; we = 1'b1;
      end
      CMD_MAX: begin
        q1 = mx; q2 = mx; q3 = mx; q4 = mx; we = 1'b1;
      end
      CMD_MIN: begin
        q1 = mn; q2 = mn; q3 = mn; q4 = mn; we = 1'b1;
      end
      CMD_RCW: begin
        q1 = p3; q2 = p1; q3 = p4; q4 = p2; we = 1'b1;
      end
      CMD_RCCW: begin
        q1 = p2; q2 = p4; q3 = p1; q4 = p3; we = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lcd_ctrl_param.sv
// LCD image controller: loads an IMG_W x IMG_H image from IROM, applies
// window commands around an op point, and writes the image back to IRB.
module lcd_ctrl_param
  import lcd_ctrl_pkg::*;
#(
  parameter  int unsigned DW    = 8,
  parameter  int unsigned IMG_W = 8,
  parameter  int unsigned IMG_H = 8,
  localparam int unsigned AW    = clog2(IMG_W * IMG_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  input  logic [DW-1:0] IROM_Q,
  output logic          IROM_EN,
  output logic [AW-1:0] IROM_A,
  output logic          IRB_RW,
  output logic [AW-1:0] IRB_A,
  output logic [DW-1:0] IRB_D,
  output logic          busy,
  output logic          done
);

  localparam int unsigned N  = IMG_W * IMG_H;
  localparam int unsigned XW = clog2(IMG_W);
  localparam int unsigned YW = clog2(IMG_H);
  localparam int unsigned CW = AW + 1;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [XW-1:0] x, x_n;
  logic [YW-1:0] y, y_n;
  logic [3:0]    cmd_q, cmd_q_n;
  logic          busy_n, rom_en_n, rw_n, done_n;
  logic [AW-1:0] rom_a_n, irb_a_n;
  logic [DW-1:0] irb_d_n;

  logic [DW-1:0] mem [N];
  logic          ld_we, win_we, alu_we;
  logic [AW-1:0] ld_addr;
  logic [AW-1:0] a1, a2, a3, a4;
  logic [DW-1:0] q1, q2, q3, q4;

  // Power-of-two dimensions make the linear address a plain {y, x} concat.
  assign a1 = {y - YW'(1), x - XW'(1)};
  assign a2 = {y - YW'(1), x};
  assign a3 = {y, x - XW'(1)};
  assign a4 = {y, x};

  lcd_win_alu #(.DW(DW)) u_alu (
    .p1  (mem[a1]),
    .p2  (mem[a2]),
    .p3  (mem[a3]),
    .p4  (mem[a4]),
    .cmd (cmd_q),
    .q1  (q1),
    .q2  (q2),
    .q3  (q3),
    .q4  (q4),
    .we  (alu_we)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= LOAD;
      cnt     <= '0;
      x       <= XW'(IMG_W / 2);
      y       <= YW'(IMG_H / 2);
      cmd_q   <= '0;
      busy    <= 1'b1;
      IROM_EN <= 1'b1;
      IROM_A  <= '0;
      IRB_RW  <= 1'b1;
      IRB_A   <= '0;
      IRB_D   <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      x       <= x_n;
      y       <= y_n;
      cmd_q   <= cmd_q_n;
      busy    <= busy_n;
      IROM_EN <= rom_en_n;
      IROM_A  <= rom_a_n;
      IRB_RW  <= rw_n;
      IRB_A   <= irb_a_n;
      IRB_D   <= irb_d_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    x_n      = x;
    y_n      = y;
    cmd_q_n  = cmd_q;
    busy_n   = busy;
    rom_en_n = 1'b1;
    rom_a_n  = IROM_A;
    rw_n     = 1'b1;
    irb_a_n  = IRB_A;
    irb_d_n  = IRB_D;
    done_n   = 1'b0;
    ld_we    = 1'b0;
    ld_addr  = AW'(cnt - CW'(2));
    win_we   = 1'b0;
    case (state)
      // Address k is issued on count k; its data lands two counts later.
      LOAD: begin
        busy_n = 1'b1;
        cnt_n  = cnt + CW'(1);
        if (cnt < CW'(N)) begin
          rom_en_n = 1'b0;
          rom_a_n  = AW'(cnt);
        end
        if (cnt >= CW'(2)) ld_we = 1'b1;
        if (cnt == CW'(N + 1)) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          cnt_n   = '0;
        end
      end
      IDLE: begin
        busy_n = 1'b0;
        if (cmd_valid && !busy) begin
          cmd_q_n = cmd;
          busy_n  = 1'b1;
          if (cmd == CMD_WRTBK) begin
            state_n = WRITE;
            rw_n    = 1'b0;
            irb_a_n = '0;
            irb_d_n = mem[AW'(0)];
            cnt_n   = CW'(1);
          end else begin
            state_n = EXEC;
          end
        end
      end
      EXEC: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        win_we  = alu_we;
        case (cmd_q)
          CMD_UP:    if (y > YW'(1))         y_n = y - YW'(1);
          CMD_DOWN:  if (y < YW'(IMG_H - 1)) y_n = y + YW'(1);
          CMD_LEFT:  if (x > XW'(1))         x_n = x - XW'(1);
          CMD_RIGHT: if (x < XW'(IMG_W - 1)) x_n = x + XW'(1);
          default: ;
        endcase
      end
      WRITE: begin
        if (cnt < CW'(N)) begin
          rw_n    = 1'b0;
          irb_a_n = AW'(cnt);
          irb_d_n = mem[AW'(cnt)];
          cnt_n   = cnt + CW'(1);
        end else if (cnt == CW'(N)) begin
          done_n = 1'b1;
          cnt_n  = cnt + CW'(1);
        end else begin
          state_n = IDLE;
          busy_n  = 1'b0;
          cnt_n   = '0;
        end
      end
      default: state_n = LOAD;
    endcase
  end

  // Image buffer is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (reset && ld_we) mem[ld_addr] <= IROM_Q;
    if (reset && win_we) begin
      mem[a1] <= q1;
      mem[a2] <= q2;
      mem[a3] <= q3;
      mem[a4] <= q4;
    end
  end

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Directed bench for lcd_ctrl_param: an 8x8/8-bit instance and a
// 16x4/10-bit instance, each with a registered IROM model.
module tb_lcd_ctrl_param;

  logic       clk;
  logic       reset, cmd_valid, rom_en0, rw0, busy0, done0;
  logic [3:0] cmd;
  logic [7:0] rom_q0, irb_d0;
  logic [5:0] rom_a0, irb_a0;
  logic [7:0] rom0 [64];
  logic [7:0] exp0 [64];
  logic [7:0] irb0 [64];

  logic       reset1, cmd_valid1, rom_en1, rw1, busy1, done1;
  logic [3:0] cmd1;
  logic [9:0] rom_q1, irb_d1;
  logic [5:0] rom_a1, irb_a1;
  logic [9:0] rom1 [64];
  logic [9:0] irb1 [64];

  int n_vec;
  int n_err;
  int t;

  lcd_ctrl_param #(.DW(8), .IMG_W(8), .IMG_H(8)) dut0 (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
    .IROM_Q(rom_q0), .IROM_EN(rom_en0), .IROM_A(rom_a0),
    .IRB_RW(rw0), .IRB_A(irb_a0), .IRB_D(irb_d0), .busy(busy0), .done(done0)
  );

  lcd_ctrl_param #(.DW(10), .IMG_W(16), .IMG_H(4)) dut1 (
    .clk(clk), .reset(reset1), .cmd(cmd1), .cmd_valid(cmd_valid1),
    .IROM_Q(rom_q1), .IROM_EN(rom_en1), .IROM_A(rom_a1),
    .IRB_RW(rw1), .IRB_A(irb_a1), .IRB_D(irb_d1), .busy(busy1), .done(done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (rom_en0 === 1'b0) rom_q0 <= rom0[rom_a0];
  always @(posedge clk) if (rom_en1 === 1'b0) rom_q1 <= rom1[rom_a1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic reload0();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    t = 0;
    while (busy0 === 1'b1 && t < 200) begin
      tick();
      t++;
    end
    chk("load_cycles", t, 65);
  endtask

  task automatic send0(input logic [3:0] c);
    chk("send_idle", busy0, 0);
    cmd = c;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
  endtask

  task automatic send1(input logic [3:0] c);
    cmd1 = c;
    cmd_valid1 = 1'b1;
    tick();
    cmd_valid1 = 1'b0;
    tick();
  endtask

  task automatic ident0();
    for (int i = 0; i < 64; i++) exp0[i] = 8'(i);
  endtask

  // Write-back; with hold set, cmd_valid stays high (cmd 9) until done.
  task automatic wb0(input bit hold);
    for (int i = 0; i < 64; i++) irb0[i] = 'x;
    cmd = 4'd0;
    cmd_valid = 1'b1;
    tick();
    cmd = 4'd9;
    cmd_valid = hold;
    t = 0;
    while (done0 !== 1'b1 && t < 200) begin
      if (rw0 === 1'b0) irb0[irb_a0] = irb_d0;
      tick();
      t++;
    end
    chk("wb_done", done0, 1);
    cmd_valid = 1'b0;
    tick();
    chk("wb_idle", busy0, 0);
  endtask

  task automatic cmp0(input string tag);
    for (int i = 0; i < 64; i++) chk($sformatf("%s[%0d]", tag, i), irb0[i], exp0[i]);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0; cmd = 4'd0; cmd_valid = 1'b0;
    reset1 = 1'b0; cmd1 = 4'd0; cmd_valid1 = 1'b0;
    for (int i = 0; i < 64; i++) begin
      rom0[i] = 8'(i);
      rom1[i] = 10'(i * 16 + 3);
    end

    // Reset values, load timing and a full write-back of buf[k]=k
    tick();
    tick();
    chk("rst_busy", busy0, 1);
    chk("rst_en", rom_en0, 1);
    chk("rst_rom_a", rom_a0, 0);
    chk("rst_rw", rw0, 1);
    chk("rst_irb_a", irb_a0, 0);
    chk("rst_irb_d", irb_d0, 0);
    chk("rst_done", done0, 0);
    reset = 1'b1;
    tick();
    chk("load_en0", rom_en0, 0);
    chk("load_a0", rom_a0, 0);
    chk("load_busy", busy0, 1);
    t = 0;
    while (busy0 === 1'b1 && t < 200) begin
      tick();
      t++;
      if (t == 63) chk("load_a63", rom_a0, 63);
    end
    chk("load_cycles", t, 65);
    chk("load_en_off", rom_en0, 1);
    cmd = 4'd0;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 64; k++) begin
      chk($sformatf("wr_rw%0d", k), rw0, 0);
      chk($sformatf("wr_a%0d", k), irb_a0, k);
      chk($sformatf("wr_d%0d", k), irb_d0, k);
      chk($sformatf("wr_done%0d", k), done0, 0);
      tick();
    end
    chk("done_pulse", done0, 1);
    chk("done_rw", rw0, 1);
    chk("done_busy", busy0, 1);
    tick();
    chk("done_clear", done0, 0);
    chk("after_busy", busy0, 0);

    // Average at the reset op point (4,4)
    reload0();
    ident0();
    send0(4'd5);
    exp0[27] = 8'd31; exp0[28] = 8'd31; exp0[35] = 8'd31; exp0[36] = 8'd31;
    wb0(1'b0);
    cmp0("avg44");

    // Saturate to (1,1) and mirror X, then saturate to (7,7) and mirror Y
    reload0();
    ident0();
    for (int i = 0; i < 5; i++) send0(4'd1);
    for (int i = 0; i < 5; i++) send0(4'd3);
    send0(4'd6);
    exp0[0] = 8'd8; exp0[8] = 8'd0; exp0[1] = 8'd9; exp0[9] = 8'd1;
    wb0(1'b0);
    cmp0("mirx11");
    for (int i = 0; i < 8; i++) send0(4'd4);
    for (int i = 0; i < 8; i++) send0(4'd2);
    send0(4'd7);
    exp0[54] = 8'd55; exp0[55] = 8'd54; exp0[62] = 8'd63; exp0[63] = 8'd62;
    wb0(1'b0);
    cmp0("miry77");

    // Average without wrap, max and min on planted windows
    rom0[27] = 8'd255; rom0[28] = 8'd255; rom0[35] = 8'd255; rom0[36] = 8'd254;
    rom0[13] = 8'd255; rom0[14] = 8'd255; rom0[21] = 8'd255; rom0[22] = 8'd254;
    rom0[41] = 8'd1;   rom0[42] = 8'd7;   rom0[49] = 8'd3;   rom0[50] = 8'd9;
    reload0();
    ident0();
    send0(4'd5);
    send0(4'd4); send0(4'd4); send0(4'd1); send0(4'd1);
    send0(4'd8);
    for (int i = 0; i < 4; i++) send0(4'd3);
    for (int i = 0; i < 4; i++) send0(4'd2);
    send0(4'd9);
    exp0[27] = 8'd254; exp0[28] = 8'd254; exp0[35] = 8'd254; exp0[36] = 8'd254;
    exp0[13] = 8'd255; exp0[14] = 8'd255; exp0[21] = 8'd255; exp0[22] = 8'd255;
    exp0[41] = 8'd1;   exp0[42] = 8'd1;   exp0[49] = 8'd1;   exp0[50] = 8'd1;
    wb0(1'b0);
    cmp0("avgmaxmin");
    for (int i = 0; i < 64; i++) rom0[i] = 8'(i);

    // Rotate CW / CCW, commands ignored while busy, no-op timing
    reload0();
    ident0();
    send0(4'd10);
    exp0[27] = 8'd35; exp0[28] = 8'd27; exp0[35] = 8'd36; exp0[36] = 8'd28;
    wb0(1'b1);
    cmp0("rcw");
    send0(4'd11);
    ident0();
    wb0(1'b0);
    cmp0("rccw");
    cmd = 4'd4;
    cmd_valid = 1'b1;
    tick();
    tick();
    cmd_valid = 1'b0;
    send0(4'd5);
    exp0[28] = 8'd32; exp0[29] = 8'd32; exp0[36] = 8'd32; exp0[37] = 8'd32;
    cmd = 4'd13;
    cmd_valid = 1'b1;
    tick();
    chk("nop_busy1", busy0, 1);
    cmd_valid = 1'b0;
    tick();
    chk("nop_busy0", busy0, 0);
    wb0(1'b0);
    cmp0("hold_nop");

    // Reset in the middle of a write-back
    cmd = 4'd0;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("mid_a20", irb_a0, 20);
    reset = 1'b0;
    tick();
    chk("abort_rw", rw0, 1);
    chk("abort_busy", busy0, 1);
    chk("abort_done", done0, 0);
    reset = 1'b1;
    tick();
    chk("restart_en", rom_en0, 0);
    chk("restart_a", rom_a0, 0);
    t = 0;
    while (busy0 === 1'b1 && t < 200) begin
      tick();
      t++;
    end
    chk("restart_cycles", t, 65);
    ident0();
    wb0(1'b0);
    cmp0("reload");

    // 16x4, 10-bit instance
    reset1 = 1'b1;
    tick();
    t = 0;
    while (busy1 === 1'b1 && t < 200) begin
      tick();
      t++;
    end
    chk("w16_load_cycles", t, 65);
    cmd1 = 4'd0;
    cmd_valid1 = 1'b1;
    tick();
    cmd_valid1 = 1'b0;
    for (int k = 0; k < 64; k++) begin
      chk($sformatf("w16_rw%0d", k), rw1, 0);
      chk($sformatf("w16_a%0d", k), irb_a1, k);
      chk($sformatf("w16_d%0d", k), irb_d1, k * 16 + 3);
      tick();
    end
    chk("w16_done", done1, 1);
    tick();
    chk("w16_done_clear", done1, 0);
    chk("w16_idle", busy1, 0);
    send1(4'd5);
    for (int i = 0; i < 3; i++) send1(4'd2);
    for (int i = 0; i < 10; i++) send1(4'd4);
    send1(4'd7);
    for (int i = 0; i < 64; i++) irb1[i] = 'x;
    cmd1 = 4'd0;
    cmd_valid1 = 1'b1;
    tick();
    cmd_valid1 = 1'b0;
    t = 0;
    while (done1 !== 1'b1 && t < 200) begin
      if (rw1 === 1'b0) irb1[irb_a1] = irb_d1;
      tick();
      t++;
    end
    chk("w16_wb2_done", done1, 1);
    tick();
    chk("w16_p22", irb1[22], 355);
    chk("w16_p23", irb1[23], 507);
    chk("w16_p24", irb1[24], 507);
    chk("w16_p39", irb1[39], 507);
    chk("w16_p40", irb1[40], 507);
    chk("w16_p46", irb1[46], 755);
    chk("w16_p47", irb1[47], 739);
    chk("w16_p62", irb1[62], 1011);
    chk("w16_p63", irb1[63], 995);
    chk("w16_p45", irb1[45], 723);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
